// File: rtl/wb_stage_buf.sv
// wb_stage_buf: two-entry skid-buffered stage between EX/MEM and writeback.
// Holds ALU/MEM/PC/IMM operands plus writeback select, destination register
// and regwrite flag; presents the head entry to the downstream 4:1 writeback mux.
// in_ready is decoded from registered occupancy only, so a downstream stall
// never ripples combinationally back to the upstream stage.
// Optional feature: define WB_PERF_CNT_EN to add the saturating stall counter
// (stall_cnt port and PERF_W parameter).
module wb_stage_buf #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 6
`ifdef WB_PERF_CNT_EN
    ,
    parameter int PERF_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [1:0]        in_sel,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_regwrite,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_d,
    output logic [1:0]        out_sel,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_regwrite
`ifdef WB_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    // Occupancy states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_head;
    logic       r_tail;
    logic       w_head_next;
    logic       w_tail_next;

    logic       w_push;
    logic       w_pop;
    logic       w_wr;
    logic       w_valid;

    // Entry storage, one slot per pointer value
    logic [DATA_W-1:0] r_alu [2];
    logic [DATA_W-1:0] r_mem [2];
    logic [DATA_W-1:0] r_pc  [2];
    logic [DATA_W-1:0] r_imm [2];
    logic [1:0]        r_sel [2];
    logic [RD_W-1:0]   r_rd  [2];
    logic              r_rw  [2];

    assign w_valid  = (r_state != ST_EMPTY);
    assign in_ready = (r_state != ST_FULL);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = w_valid & out_ready;
    // A flushed push must not land in storage (it could resurface later)
    assign w_wr     = w_push & ~flush;

    // Next occupancy and pointer values; flush overrides any push/pop
    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        if (flush) begin
            w_state_next = ST_EMPTY;
            w_head_next  = 1'b0;
            w_tail_next  = 1'b0;
        end else begin
            if (w_push) w_tail_next = ~r_tail;
            if (w_pop)  w_head_next = ~r_head;
            case (r_state)
                ST_EMPTY: if (w_push) w_state_next = ST_ONE;
                ST_ONE: begin
                    if (w_push && !w_pop)      w_state_next = ST_FULL;
                    else if (w_pop && !w_push) w_state_next = ST_EMPTY;
                    else                       w_state_next = ST_ONE;
                end
                ST_FULL:  if (w_pop) w_state_next = ST_ONE;
                default:  w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Occupancy state and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            // Capture the incoming entry into the slot addressed by the tail pointer
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_alu[gi] <= '0;
                    r_mem[gi] <= '0;
                    r_pc[gi]  <= '0;
                    r_imm[gi] <= '0;
                    r_sel[gi] <= '0;
                    r_rd[gi]  <= '0;
                    r_rw[gi]  <= 1'b0;
                end else if (w_wr && (r_tail == 1'(gi))) begin
                    r_alu[gi] <= in_alu;
                    r_mem[gi] <= in_mem;
                    r_pc[gi]  <= in_pc;
                    r_imm[gi] <= in_imm;
                    r_sel[gi] <= in_sel;
                    r_rd[gi]  <= in_rd;
                    r_rw[gi]  <= in_regwrite;
                end
            end
        end
    endgenerate

    // Head entry drives the writeback mux operands directly from storage
    assign out_valid    = w_valid;
    assign out_a        = r_alu[r_head];
    assign out_b        = r_mem[r_head];
    assign out_c        = r_pc[r_head];
    assign out_d        = r_imm[r_head];
    assign out_sel      = r_sel[r_head];
    assign out_rd       = r_rd[r_head];
    // Stale slots after a flush or drain must never write the register file
    assign out_regwrite = w_valid & r_rw[r_head];

`ifdef WB_PERF_CNT_EN
    logic [PERF_W-1:0] r_stall_cnt;

    // Count cycles where a valid head is blocked downstream; saturate, ignore flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Testbench for wb_stage_buf: table-driven vectors plus hand-written
// sequences for single pass, streaming, asynchronous reset and stall counting.
// Define WB_PERF_CNT_EN to include the stall counter checks.
module tb_wb_stage_buf;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu, in_mem, in_pc, in_imm;
    logic [1:0]  in_sel;
    logic [5:0]  in_rd;
    logic        in_regwrite;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b, out_c, out_d;
    logic [1:0]  out_sel;
    logic [5:0]  out_rd;
    logic        out_regwrite;

    int checks;
    int failures;

`ifdef WB_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic        in_ready2, out_valid2, out_regwrite2;
    logic [31:0] out_a2, out_b2, out_c2, out_d2;
    logic [1:0]  out_sel2;
    logic [5:0]  out_rd2;
    logic [3:0]  stall_cnt2;
`endif

    wb_stage_buf dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc), .in_imm(in_imm),
        .in_sel(in_sel), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_sel(out_sel), .out_rd(out_rd), .out_regwrite(out_regwrite)
`ifdef WB_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

`ifdef WB_PERF_CNT_EN
    wb_stage_buf #(.PERF_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc), .in_imm(in_imm),
        .in_sel(in_sel), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_a(out_a2), .out_b(out_b2), .out_c(out_c2), .out_d(out_d2),
        .out_sel(out_sel2), .out_rd(out_rd2), .out_regwrite(out_regwrite2),
        .stall_cnt(stall_cnt2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] val;
        logic [1:0]  sel;
        logic [5:0]  rd;
        logic        rw;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic        chkd;
        logic [31:0] e_a;
        logic [1:0]  e_sel;
        logic [5:0]  e_rd;
        logic        e_rw;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic iv, input logic [31:0] val, input logic [1:0] sel,
                                input logic [5:0] rd, input logic rw, input logic ordy,
                                input logic fl, input logic e_ov, input logic e_ir,
                                input logic chkd, input logic [31:0] e_a, input logic [1:0] e_sel,
                                input logic [5:0] e_rd, input logic e_rw);
        vec_t v;
        v.iv = iv; v.val = val; v.sel = sel; v.rd = rd; v.rw = rw; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.chkd = chkd; v.e_a = e_a; v.e_sel = e_sel;
        v.e_rd = e_rd; v.e_rw = e_rw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drive one entry; operands derived from val so every lane is distinct
    task automatic drive(input logic iv, input logic [31:0] val, input logic [1:0] sel,
                         input logic [5:0] rd, input logic rw);
        in_valid    = iv;
        in_alu      = val;
        in_mem      = val + 32'h1000;
        in_pc       = val + 32'h2000;
        in_imm      = val + 32'h3000;
        in_sel      = sel;
        in_rd       = rd;
        in_regwrite = rw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_a"}, out_a, 32'd0);
        chk({tag, "_out_b"}, out_b, 32'd0);
        chk({tag, "_out_c"}, out_c, 32'd0);
        chk({tag, "_out_d"}, out_d, 32'd0);
        chk({tag, "_out_sel"}, 32'(out_sel), 32'd0);
        chk({tag, "_out_rd"}, 32'(out_rd), 32'd0);
        chk({tag, "_out_regwrite"}, 32'(out_regwrite), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 2'd0, 6'd0, 1'b0);

        //             iv  val     sel rd  rw ordy fl  ov ir chk a       sel rd  rw
        vecs[0]  = mk(1, 32'hA,  0, 1,  1, 0, 0,  1, 1, 1, 32'hA,  0, 1,  1);
        vecs[1]  = mk(1, 32'hB,  1, 2,  0, 0, 0,  1, 0, 1, 32'hA,  0, 1,  1);
        vecs[2]  = mk(1, 32'hC,  2, 3,  1, 0, 0,  1, 0, 1, 32'hA,  0, 1,  1);
        vecs[3]  = mk(0, 32'h0,  0, 0,  0, 1, 0,  1, 1, 1, 32'hB,  1, 2,  0);
        vecs[4]  = mk(0, 32'h0,  0, 0,  0, 1, 0,  0, 1, 0, 32'h0,  0, 0,  0);
        vecs[5]  = mk(1, 32'hD,  1, 4,  1, 0, 0,  1, 1, 1, 32'hD,  1, 4,  1);
        vecs[6]  = mk(1, 32'hE,  2, 5,  0, 0, 0,  1, 0, 1, 32'hD,  1, 4,  1);
        vecs[7]  = mk(1, 32'hF,  3, 6,  1, 1, 1,  0, 1, 0, 32'h0,  0, 0,  0);
        vecs[8]  = mk(1, 32'h21, 3, 63, 1, 1, 0,  1, 1, 1, 32'h21, 3, 63, 1);
        vecs[9]  = mk(1, 32'h22, 2, 7,  1, 1, 0,  1, 1, 1, 32'h22, 2, 7,  1);
        vecs[10] = mk(0, 32'h0,  0, 0,  0, 0, 0,  1, 1, 1, 32'h22, 2, 7,  1);
        vecs[11] = mk(0, 32'h0,  0, 0,  0, 0, 0,  1, 1, 1, 32'h22, 2, 7,  1);
        vecs[12] = mk(0, 32'h0,  0, 0,  0, 1, 0,  0, 1, 0, 32'h0,  0, 0,  0);
        vecs[13] = mk(1, 32'h31, 0, 9,  1, 0, 0,  1, 1, 1, 32'h31, 0, 9,  1);
        vecs[14] = mk(0, 32'h0,  0, 0,  0, 1, 1,  0, 1, 0, 32'h0,  0, 0,  0);
        vecs[15] = mk(1, 32'h32, 1, 10, 1, 0, 0,  1, 1, 1, 32'h32, 1, 10, 1);

        // Reset state
        #12;
        chk_reset_outputs("reset");
        $display("txn reset ov=%b ir=%b", out_valid, in_ready);
        @(negedge clk);
        rst_n = 1'b1;

        // Single pass
        in_valid = 1'b1; in_alu = 32'h11; in_mem = 32'h22; in_pc = 32'h33; in_imm = 32'h44;
        in_sel = 2'b01; in_rd = 6'd5; in_regwrite = 1'b1; out_ready = 1'b1;
        step();
        $display("txn single_pass ov=%b b=%h sel=%0d rd=%0d rw=%b", out_valid, out_b, out_sel, out_rd, out_regwrite);
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_a", out_a, 32'h11);
        chk("single_out_b", out_b, 32'h22);
        chk("single_out_c", out_c, 32'h33);
        chk("single_out_d", out_d, 32'h44);
        chk("single_out_sel", 32'(out_sel), 32'd1);
        chk("single_out_rd", 32'(out_rd), 32'd5);
        chk("single_out_regwrite", 32'(out_regwrite), 32'd1);
        in_valid = 1'b0;
        step();
        chk("single_drain_out_valid", 32'(out_valid), 32'd0);
        chk("single_drain_out_regwrite", 32'(out_regwrite), 32'd0);

        // Table-driven vectors: backpressure, ordering, flush, held head
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].iv, vecs[i].val, vecs[i].sel, vecs[i].rd, vecs[i].rw);
            out_ready = vecs[i].ordy;
            flush = vecs[i].fl;
            step();
            $display("txn vec%0d iv=%b ordy=%b fl=%b -> ov=%b ir=%b a=%h sel=%0d rd=%0d rw=%b",
                     i, vecs[i].iv, vecs[i].ordy, vecs[i].fl, out_valid, in_ready, out_a, out_sel, out_rd, out_regwrite);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_out_regwrite", i), 32'(out_regwrite), 32'(vecs[i].e_rw));
            if (vecs[i].chkd) begin
                chk($sformatf("vec%0d_out_a", i), out_a, vecs[i].e_a);
                chk($sformatf("vec%0d_out_b", i), out_b, vecs[i].e_a + 32'h1000);
                chk($sformatf("vec%0d_out_c", i), out_c, vecs[i].e_a + 32'h2000);
                chk($sformatf("vec%0d_out_d", i), out_d, vecs[i].e_a + 32'h3000);
                chk($sformatf("vec%0d_out_sel", i), 32'(out_sel), 32'(vecs[i].e_sel));
                chk($sformatf("vec%0d_out_rd", i), 32'(out_rd), 32'(vecs[i].e_rd));
            end
        end
        flush = 1'b0;
        drive(1'b0, 32'd0, 2'd0, 6'd0, 1'b0);
        out_ready = 1'b1;
        step();
        chk("predrain_out_valid", 32'(out_valid), 32'd0);

        // Streaming: push and pop every cycle, values 1..10
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 32'(k), 2'(k), 6'(k), 1'b1);
            step();
            $display("txn stream%0d ov=%b ir=%b a=%h", k, out_valid, in_ready, out_a);
            chk($sformatf("stream%0d_out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d_in_ready", k), 32'(in_ready), 32'd1);
            chk($sformatf("stream%0d_out_a", k), out_a, 32'(k));
            chk($sformatf("stream%0d_out_sel", k), 32'(out_sel), 32'(k % 4));
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 2'd3, 6'd12, 1'b1);
        step();
        drive(1'b1, 32'h66, 2'd2, 6'd13, 1'b1);
        step();
        chk("prereset_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        $display("txn async_reset ov=%b ir=%b a=%h", out_valid, in_ready, out_a);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef WB_PERF_CNT_EN
        // Stall counting: 5 stalled cycles, then saturation of the 4-bit copy
        chk("perf_reset_stall_cnt", 32'(stall_cnt), 32'd0);
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 2'd0, 6'd1, 1'b1);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        $display("txn perf5 stall_cnt=%0d", stall_cnt);
        chk("perf_stall_cnt_5", 32'(stall_cnt), 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf_flush_keeps_cnt", 32'(stall_cnt), 32'd6);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (14) step();
        $display("txn perf20 stall_cnt=%0d sat=%0d", stall_cnt, stall_cnt2);
        chk("perf_stall_cnt_20", 32'(stall_cnt), 32'd20);
        chk("perf_sat_stall_cnt", 32'(stall_cnt2), 32'd15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global timeout so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
